// File: rtl/rf_pkg.sv
// ----------------------------------------------------------------------------
// rf_pkg
// Shared constants and types for the 2-read / 1-write register file.
//   RF_WIDTH     : default data width of one register
//   RF_DEPTH     : default number of architectural registers
//   RF_AW        : default register-address width
//   rf_word_t    : one data word
//   rf_addr_t    : one register address
//   RF_ZERO_ADDR : address of the hardwired-zero register
// ----------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_WIDTH = 16;
    localparam int RF_DEPTH = 8;
    localparam int RF_AW    = 3;

    typedef logic [RF_WIDTH-1:0] rf_word_t;
    typedef logic [RF_AW-1:0]    rf_addr_t;

    localparam rf_addr_t RF_ZERO_ADDR = 3'd0;

endpackage : rf_pkg

// File: rtl/rf_cell.sv
// ----------------------------------------------------------------------------
// rf_cell
// One WIDTH-bit storage register with load enable and asynchronous
// active-high reset. The register file instantiates one per writable register.
// Ports:
//   clk_i  : rising-edge clock
//   rst_i  : asynchronous active-high reset, clears the stored word
//   load_i : capture d_i on the next rising edge
//   d_i    : data to store
//   q_o    : stored word
// ----------------------------------------------------------------------------
module rf_cell #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-state: load new data or hold the current word.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = d_i;
        end else begin
            data_d = data_q;
        end
    end

    // Storage register with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule : rf_cell

// File: rtl/reg_file_2r1w.sv
// ----------------------------------------------------------------------------
// reg_file_2r1w
// Register file with one synchronous write port and two registered read
// ports. Register 0 reads as zero; addresses >= DEPTH are not writable and
// read as zero. Read data and its valid flag appear one cycle after the
// request; a port that is not requested holds its data and drops valid.
//
// Build option:
//   RF_BYPASS_EN defined   : write-first, a read on the same edge as a
//                            qualifying write to the same address returns WD.
//   RF_BYPASS_EN undefined : read-first, that read returns the old value.
//
// Ports:
//   CLK        : rising-edge clock
//   R          : asynchronous active-high reset (storage and outputs)
//   WE, WA, WD : write enable, address, data
//   RE_A, RA_A : read request and address, port A
//   RE_B, RA_B : read request and address, port B
//   QA, VA     : registered read data and valid, port A
//   QB, VB     : registered read data and valid, port B
// ----------------------------------------------------------------------------
module reg_file_2r1w
    import rf_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = RF_AW
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             WE,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] WD,
    input  logic             RE_A,
    input  logic [AW-1:0]    RA_A,
    input  logic             RE_B,
    input  logic [AW-1:0]    RA_B,
    output logic [WIDTH-1:0] QA,
    output logic [WIDTH-1:0] QB,
    output logic             VA,
    output logic             VB
);

    localparam int NSLOT = 2 ** AW;

    // Every address slot has an entry so reads index without range checks;
    // slot 0 and slots >= DEPTH are tied to zero.
    logic [WIDTH-1:0] regs_s [NSLOT];

    logic             wr_ok_s;
    logic [WIDTH-1:0] rdata_a_s;
    logic [WIDTH-1:0] rdata_b_s;

    logic [WIDTH-1:0] qa_q, qa_d;
    logic [WIDTH-1:0] qb_q, qb_d;
    logic             va_q, va_d;
    logic             vb_q, vb_d;

    // Write qualifies only for a real, in-range, non-zero register.
    assign wr_ok_s = WE && (WA != AW'(RF_ZERO_ADDR)) && (32'(WA) < 32'(DEPTH));

    assign regs_s[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_cell
            rf_cell #(
                .WIDTH (WIDTH)
            ) u_cell (
                .clk_i  (CLK),
                .rst_i  (R),
                .load_i (wr_ok_s && (WA == AW'(gi))),
                .d_i    (WD),
                .q_o    (regs_s[gi])
            );
        end
        for (gi = DEPTH; gi < NSLOT; gi++) begin : g_zero
            assign regs_s[gi] = '0;
        end
    endgenerate

    // Port A read data, with optional same-edge write forwarding.
    always_comb begin
        rdata_a_s = regs_s[RA_A];
`ifdef RF_BYPASS_EN
        if (wr_ok_s && (WA == RA_A)) begin
            rdata_a_s = WD;
        end else begin
            rdata_a_s = regs_s[RA_A];
        end
`endif
    end

    // Port B read data, with optional same-edge write forwarding.
    always_comb begin
        rdata_b_s = regs_s[RA_B];
`ifdef RF_BYPASS_EN
        if (wr_ok_s && (WA == RA_B)) begin
            rdata_b_s = WD;
        end else begin
            rdata_b_s = regs_s[RA_B];
        end
`endif
    end

    // Output next-state: capture on request, otherwise hold data and drop valid.
    always_comb begin
        qa_d = qa_q;
        qb_d = qb_q;
        va_d = RE_A;
        vb_d = RE_B;
        if (RE_A) begin
            qa_d = rdata_a_s;
        end else begin
            qa_d = qa_q;
        end
        if (RE_B) begin
            qb_d = rdata_b_s;
        end else begin
            qb_d = qb_q;
        end
    end

    // Output registers, cleared asynchronously so no pending read survives reset.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            qa_q <= '0;
            qb_q <= '0;
            va_q <= 1'b0;
            vb_q <= 1'b0;
        end else begin
            qa_q <= qa_d;
            qb_q <= qb_d;
            va_q <= va_d;
            vb_q <= vb_d;
        end
    end

    assign QA = qa_q;
    assign QB = qb_q;
    assign VA = va_q;
    assign VB = vb_q;

endmodule : reg_file_2r1w

// File: tb/tb_reg_file_2r1w.sv
// ----------------------------------------------------------------------------
// tb_reg_file_2r1w
// Directed self-checking bench for reg_file_2r1w built with DEPTH=6, so
// addresses 6 and 7 are out of range. Expected values are hand-computed;
// the same-edge read/write result follows RF_BYPASS_EN.
// ----------------------------------------------------------------------------
module tb_reg_file_2r1w;

    logic        CLK;
    logic        R;
    logic        WE;
    logic [2:0]  WA;
    logic [15:0] WD;
    logic        RE_A;
    logic [2:0]  RA_A;
    logic        RE_B;
    logic [2:0]  RA_B;
    logic [15:0] QA;
    logic [15:0] QB;
    logic        VA;
    logic        VB;

    int checks   = 0;
    int failures = 0;

`ifdef RF_BYPASS_EN
    localparam logic [15:0] CONFLICT_EXP = 16'h00FF;
`else
    localparam logic [15:0] CONFLICT_EXP = 16'h0001;
`endif

    reg_file_2r1w #(
        .WIDTH (16),
        .DEPTH (6),
        .AW    (3)
    ) dut (
        .CLK  (CLK),
        .R    (R),
        .WE   (WE),
        .WA   (WA),
        .WD   (WD),
        .RE_A (RE_A),
        .RA_A (RA_A),
        .RE_B (RE_B),
        .RA_B (RA_B),
        .QA   (QA),
        .QB   (QB),
        .VA   (VA),
        .VB   (VB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WE = 1'b0; WA = 3'd0; WD = 16'h0000;
        RE_A = 1'b0; RA_A = 3'd0; RE_B = 1'b0; RA_B = 3'd0;
    endtask

    initial begin
        idle();
        R = 1'b1;
        #1;
        chk("rst_qa", QA, 16'h0000);
        chk("rst_qb", QB, 16'h0000);
        chk("rst_va", {15'd0, VA}, 16'h0000);
        chk("rst_vb", {15'd0, VB}, 16'h0000);
        tick();
        R = 1'b0;

        // After reset every address reads zero on both ports.
        for (int a = 0; a < 8; a++) begin
            RE_A = 1'b1; RA_A = 3'(a);
            RE_B = 1'b1; RA_B = 3'(7 - a);
            tick();
            chk("post_rst_qa", QA, 16'h0000);
            chk("post_rst_qb", QB, 16'h0000);
            chk("post_rst_va", {15'd0, VA}, 16'h0001);
            chk("post_rst_vb", {15'd0, VB}, 16'h0001);
        end

        // Write register 3, then read it back.
        idle();
        WE = 1'b1; WA = 3'd3; WD = 16'hBEEF;
        tick();
        chk("wr3_va_low", {15'd0, VA}, 16'h0000);
        idle();
        RE_A = 1'b1; RA_A = 3'd3;
        tick();
        chk("rd3_qa", QA, 16'hBEEF);
        chk("rd3_va", {15'd0, VA}, 16'h0001);

        // Writes to register 0 are ignored.
        idle();
        WE = 1'b1; WA = 3'd0; WD = 16'h1234;
        tick();
        idle();
        RE_A = 1'b1; RA_A = 3'd0; RE_B = 1'b1; RA_B = 3'd0;
        tick();
        chk("r0_qa", QA, 16'h0000);
        chk("r0_qb", QB, 16'h0000);
        chk("r0_va", {15'd0, VA}, 16'h0001);
        chk("r0_vb", {15'd0, VB}, 16'h0001);

        // Same-edge write and read of register 5.
        idle();
        WE = 1'b1; WA = 3'd5; WD = 16'h0001;
        tick();
        idle();
        WE = 1'b1; WA = 3'd5; WD = 16'h00FF;
        RE_B = 1'b1; RA_B = 3'd5;
        tick();
        chk("conflict_qb", QB, CONFLICT_EXP);
        chk("conflict_vb", {15'd0, VB}, 16'h0001);
        chk("conflict_va_low", {15'd0, VA}, 16'h0000);
        chk("conflict_qa_hold", QA, 16'h0000);
        idle();
        RE_B = 1'b1; RA_B = 3'd5;
        tick();
        chk("after_conflict_qb", QB, 16'h00FF);

        // Write to register 0 never forwards, in either mode.
        idle();
        WE = 1'b1; WA = 3'd0; WD = 16'hABCD;
        RE_A = 1'b1; RA_A = 3'd0;
        tick();
        chk("r0_same_edge_qa", QA, 16'h0000);

        // Hold: QA keeps its value and VA stays low while register 3 changes.
        idle();
        RE_A = 1'b1; RA_A = 3'd3;
        tick();
        chk("hold_start_qa", QA, 16'hBEEF);
        idle();
        WE = 1'b1; WA = 3'd3; WD = 16'h1111;
        tick();
        chk("hold1_qa", QA, 16'hBEEF);
        chk("hold1_va", {15'd0, VA}, 16'h0000);
        WD = 16'h2222;
        tick();
        chk("hold2_qa", QA, 16'hBEEF);
        chk("hold2_va", {15'd0, VA}, 16'h0000);
        WD = 16'h3333;
        tick();
        chk("hold3_qa", QA, 16'hBEEF);
        chk("hold3_va", {15'd0, VA}, 16'h0000);
        idle();
        RE_A = 1'b1; RA_A = 3'd3;
        tick();
        chk("hold_end_qa", QA, 16'h3333);

        // Dual read of the same register.
        idle();
        WE = 1'b1; WA = 3'd2; WD = 16'h5A5A;
        tick();
        idle();
        RE_A = 1'b1; RA_A = 3'd2; RE_B = 1'b1; RA_B = 3'd2;
        tick();
        chk("dual_qa", QA, 16'h5A5A);
        chk("dual_qb", QB, 16'h5A5A);

        // Out-of-range writes ignored, reads return zero.
        idle();
        WE = 1'b1; WA = 3'd7; WD = 16'h7777;
        tick();
        WA = 3'd6; WD = 16'h6666;
        tick();
        idle();
        RE_A = 1'b1; RA_A = 3'd7; RE_B = 1'b1; RA_B = 3'd6;
        tick();
        chk("oor7_qa", QA, 16'h0000);
        chk("oor6_qb", QB, 16'h0000);
        chk("oor_va", {15'd0, VA}, 16'h0001);
        chk("oor_vb", {15'd0, VB}, 16'h0001);
        idle();
        RE_A = 1'b1; RA_A = 3'd5; RE_B = 1'b1; RA_B = 3'd2;
        tick();
        chk("last_reg_qa", QA, 16'h00FF);
        chk("reg2_qb", QB, 16'h5A5A);

        // Reset mid-cycle while both ports are valid; a write during reset is lost.
        idle();
        RE_A = 1'b1; RA_A = 3'd3; RE_B = 1'b1; RA_B = 3'd5;
        tick();
        chk("pre_rst_qa", QA, 16'h3333);
        chk("pre_rst_va", {15'd0, VA}, 16'h0001);
        #2;
        R = 1'b1;
        #1;
        chk("mid_rst_qa", QA, 16'h0000);
        chk("mid_rst_qb", QB, 16'h0000);
        chk("mid_rst_va", {15'd0, VA}, 16'h0000);
        chk("mid_rst_vb", {15'd0, VB}, 16'h0000);
        idle();
        WE = 1'b1; WA = 3'd3; WD = 16'h9999;
        RE_A = 1'b1; RA_A = 3'd3;
        tick();
        chk("in_rst_va", {15'd0, VA}, 16'h0000);
        R = 1'b0;
        idle();
        RE_A = 1'b1; RA_A = 3'd3; RE_B = 1'b1; RA_B = 3'd5;
        tick();
        chk("after_rst_qa", QA, 16'h0000);
        chk("after_rst_qb", QB, 16'h0000);
        chk("after_rst_va", {15'd0, VA}, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_file_2r1w
